// File: rtl/instruction_assembler_if.sv
// -----------------------------------------------------------------------------
// instruction_assembler_if
//   Beat-stream input, instruction output and flush control for
//   instruction_assembler.
//
//   master : instruction-memory side / consumer side (drives beats, out_ready,
//            flush)
//   slave  : the assembler itself
//
//   flush     : synchronous clear of partial instruction and output stage
//   in_data   : instruction beat, DATA_W bits
//   in_valid  : in_data is valid
//   in_ready  : assembler accepts a beat this cycle
//   out_valid : inst and decoded fields are valid
//   out_ready : consumer takes the instruction this cycle
//   inst      : assembled instruction, INST_W bits
//   opcode    : inst[31:26]
//   addr_a    : inst[25:21] (rs)
//   addr_b    : inst[20:16] (rt)
//   mux_a     : inst[20:16] (rt)
//   mux_b     : inst[15:11] (rd)
//   imm       : inst[15:0]
//   busy      : a partial instruction is held
// -----------------------------------------------------------------------------
interface instruction_assembler_if #(
  parameter int DATA_W = 8,
  parameter int INST_W = 32
);
  logic              flush;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] inst;
  logic [5:0]        opcode;
  logic [4:0]        addr_a;
  logic [4:0]        addr_b;
  logic [4:0]        mux_a;
  logic [4:0]        mux_b;
  logic [15:0]       imm;
  logic              busy;

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, out_valid, inst, opcode, addr_a, addr_b,
           mux_a, mux_b, imm, busy
  );

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, out_valid, inst, opcode, addr_a, addr_b,
           mux_a, mux_b, imm, busy
  );
endinterface

// File: rtl/instruction_assembler.sv
// -----------------------------------------------------------------------------
// instruction_assembler
//   Collects BEATS = INST_W/DATA_W beats into one instruction, then presents it
//   with its register-address fields decoded through a registered output stage.
//   The next instruction can be gathered while the current one waits; only the
//   final beat stalls while the output stage is full and not being drained.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (clears control and data)
//     bus   : instruction_assembler_if.slave (beat input, instruction output,
//             flush, busy)
//
//   Build option:
//     INSTREG_BIG_ENDIAN_EN undefined : beat k -> inst[DATA_W*k +: DATA_W]
//                                       (first beat least significant)
//     INSTREG_BIG_ENDIAN_EN defined   : beat k -> inst[INST_W-1-DATA_W*k -: DATA_W]
//                                       (first beat most significant)
//
//   INST_W must be a multiple of DATA_W, INST_W >= 32, BEATS >= 2. For wider
//   instructions the decoded fields come from bits [31:0].
// -----------------------------------------------------------------------------
module instruction_assembler #(
  parameter int DATA_W = 8,
  parameter int INST_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  instruction_assembler_if.slave  bus
);

  localparam int BEATS = INST_W / DATA_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  // Drop one beat into its lane of the assembly word.
  function automatic logic [INST_W-1:0] place_beat(
    input logic [INST_W-1:0] word,
    input logic [CNT_W-1:0]  idx,
    input logic [DATA_W-1:0] beat
  );
    logic [INST_W-1:0] r;
    r = word;
`ifdef INSTREG_BIG_ENDIAN_EN
    r[INST_W-1-DATA_W*int'(idx) -: DATA_W] = beat;
`else
    r[DATA_W*int'(idx) +: DATA_W] = beat;
`endif
    return r;
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic [INST_W-1:0] asm_q;
  logic [INST_W-1:0] asm_nxt;

  logic              vld_p1;
  logic [INST_W-1:0] inst_p1;
  logic [5:0]        opcode_p1;
  logic [4:0]        addr_a_p1;
  logic [4:0]        addr_b_p1;
  logic [4:0]        mux_a_p1;
  logic [4:0]        mux_b_p1;
  logic [15:0]       imm_p1;

  logic last_beat;
  logic in_ready_c;
  logic accept;
  logic complete;

  // The final beat needs the output stage to be free (empty or draining);
  // earlier beats only touch the assembly buffer and are never held off,
  // except by flush.
  assign last_beat  = (cnt == LAST);
  assign in_ready_c = !bus.flush && (!last_beat || !vld_p1 || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign complete   = accept && last_beat;
  assign asm_nxt    = place_beat(asm_q, cnt, bus.in_data);

  // ---- stage p0: beat collection ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else if (accept) begin
      if (last_beat) begin
        cnt <= '0;
      end else begin
        cnt   <= cnt + 1'b1;
        asm_q <= asm_nxt;
      end
    end
  end

  // ---- stage p1: output stage ----
  // A completing beat takes priority over a drain so that a drain and a new
  // instruction in the same cycle leave out_valid high with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
    end else if (complete) begin
      vld_p1 <= 1'b1;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Fields are decoded from the merged word, not from inst_p1, so they are
  // valid in the same cycle as inst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_p1   <= '0;
      opcode_p1 <= '0;
      addr_a_p1 <= '0;
      addr_b_p1 <= '0;
      mux_a_p1  <= '0;
      mux_b_p1  <= '0;
      imm_p1    <= '0;
    end else if (complete) begin
      inst_p1   <= asm_nxt;
      opcode_p1 <= asm_nxt[31:26];
      addr_a_p1 <= asm_nxt[25:21];
      addr_b_p1 <= asm_nxt[20:16];
      mux_a_p1  <= asm_nxt[20:16];
      mux_b_p1  <= asm_nxt[15:11];
      imm_p1    <= asm_nxt[15:0];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = (cnt != '0);
  assign bus.out_valid = vld_p1;
  assign bus.inst      = inst_p1;
  assign bus.opcode    = opcode_p1;
  assign bus.addr_a    = addr_a_p1;
  assign bus.addr_b    = addr_b_p1;
  assign bus.mux_a     = mux_a_p1;
  assign bus.mux_b     = mux_b_p1;
  assign bus.imm       = imm_p1;

endmodule

// File: tb/tb_instruction_assembler.sv
// Testbench for instruction_assembler (DATA_W=8, INST_W=32).
// Inputs are driven on the falling edge; combinational outputs are sampled
// 1 ns later and registered outputs 1 ns after the rising edge.
module tb_instruction_assembler;
  localparam int DATA_W = 8;
  localparam int INST_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_assembler_if #(.DATA_W(DATA_W), .INST_W(INST_W)) bus ();

  instruction_assembler #(.DATA_W(DATA_W), .INST_W(INST_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [7:0]  m_beats[$];
  bit          m_pend;
  logic [31:0] m_inst;
  logic        last_rdy;
  logic        last_busy;

  // Byte k of an instruction in stream order.
  function automatic logic [7:0] beat_of(input logic [31:0] word, input int k);
`ifdef INSTREG_BIG_ENDIAN_EN
    return 8'((word >> (8 * (3 - k))) & 32'hff);
`else
    return 8'((word >> (8 * k)) & 32'hff);
`endif
  endfunction

  function automatic logic [31:0] assemble();
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef INSTREG_BIG_ENDIAN_EN
      r = r | (32'(m_beats[k]) << (8 * (3 - k)));
`else
      r = r | (32'(m_beats[k]) << (8 * k));
`endif
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(m_pend));
    check({tag, "_inst"},      64'(bus.inst),      64'(m_inst));
    check({tag, "_opcode"},    64'(bus.opcode),    64'((m_inst >> 26) & 32'h3f));
    check({tag, "_addr_a"},    64'(bus.addr_a),    64'((m_inst >> 21) & 32'h1f));
    check({tag, "_addr_b"},    64'(bus.addr_b),    64'((m_inst >> 16) & 32'h1f));
    check({tag, "_mux_a"},     64'(bus.mux_a),     64'((m_inst >> 16) & 32'h1f));
    check({tag, "_mux_b"},     64'(bus.mux_b),     64'((m_inst >> 11) & 32'h1f));
    check({tag, "_imm"},       64'(bus.imm),       64'(m_inst & 32'hffff));
  endtask

  // One clock cycle checked against the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic ordy, input logic fl,
                       input string tag);
    logic exp_rdy;
    bit   done;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    exp_rdy   = !fl && (m_beats.size() != 3 || !m_pend || ordy);
    last_rdy  = bus.in_ready;
    last_busy = bus.busy;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
    check({tag, "_busy"},     64'(bus.busy),     64'(m_beats.size() != 0));
    if (fl) begin
      m_beats.delete();
      m_pend = 1'b0;
    end else begin
      done = 1'b0;
      if (v && exp_rdy) begin
        m_beats.push_back(d);
        if (m_beats.size() == 4) begin
          m_inst = assemble();
          m_beats.delete();
          m_pend = 1'b1;
          done   = 1'b1;
        end
      end
      if (!done && m_pend && ordy) m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic send_inst(input logic [31:0] word, input logic ordy, input string tag);
    for (int k = 0; k < 4; k++) cycle(1'b1, beat_of(word, k), ordy, 1'b0, tag);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_rst_inst"},      64'(bus.inst),      64'(0));
    check({tag, "_rst_fields"},
          64'({bus.opcode, bus.addr_a, bus.addr_b, bus.mux_a, bus.mux_b, bus.imm}), 64'(0));
    check({tag, "_rst_busy"},      64'(bus.busy),      64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "_rel_in_ready"}, 64'(bus.in_ready), 64'(1));
    m_beats.delete();
    m_pend = 1'b0;
    m_inst = 32'h0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        ordy;
    logic        fl;
    logic        exp_rdy;
    logic        exp_busy;
    logic        exp_ov;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t tbl[6];

  localparam logic [31:0] I0 = 32'h0143_4820;

  logic [31:0] b2b_words[3];
  logic [31:0] got[$];
  int          pulses;
  int          pulse_cyc[$];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    m_pend        = 1'b0;
    m_inst        = 32'h0;

    tbl[0] = '{1'b1, beat_of(I0, 0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, beat_of(I0, 1), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2] = '{1'b1, beat_of(I0, 2), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[3] = '{1'b1, beat_of(I0, 3), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, I0};
    tbl[4] = '{1'b0, 8'h00,          1'b1, 1'b0, 1'b1, 1'b0, 1'b0, I0};
    tbl[5] = '{1'b0, 8'h00,          1'b1, 1'b0, 1'b1, 1'b0, 1'b0, I0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_reset("init");

    // Decode table: one instruction, out_valid for exactly one cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid  = tbl[i].v;
      bus.in_data   = tbl[i].d;
      bus.out_ready = tbl[i].ordy;
      bus.flush     = tbl[i].fl;
      #1;
      check($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_busy", i),     64'(bus.busy),     64'(tbl[i].exp_busy));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_ov));
      check($sformatf("tbl%0d_inst", i),      64'(bus.inst),      64'(tbl[i].exp_inst));
      if (i == 3) begin
        check("dec_opcode", 64'(bus.opcode), 64'(0));
        check("dec_addr_a", 64'(bus.addr_a), 64'(10));
        check("dec_addr_b", 64'(bus.addr_b), 64'(3));
        check("dec_mux_a",  64'(bus.mux_a),  64'(3));
        check("dec_mux_b",  64'(bus.mux_b),  64'(9));
        check("dec_imm",    64'(bus.imm),    64'(16'h4820));
      end
    end

    // Backpressure: 8 beats with out_ready low.
    do_reset("bp");
    send_inst(32'hDEAD_BEEF, 1'b0, "bp_a");
    for (int k = 0; k < 3; k++) cycle(1'b1, beat_of(32'h1234_5678, k), 1'b0, 1'b0, "bp_b");
    check("bp_hold_inst", 64'(bus.inst), 64'(32'hDEAD_BEEF));
    for (int r = 0; r < 2; r++) begin
      cycle(1'b1, beat_of(32'h1234_5678, 3), 1'b0, 1'b0, "bp_stall");
      check("bp_stall_rdy",   64'(last_rdy),  64'(0));
      check("bp_stall_busy",  64'(last_busy), 64'(1));
      check("bp_stall_inst",  64'(bus.inst),  64'(32'hDEAD_BEEF));
      check("bp_stall_valid", 64'(bus.out_valid), 64'(1));
    end
    cycle(1'b1, beat_of(32'h1234_5678, 3), 1'b1, 1'b0, "bp_go");
    check("bp_go_rdy",   64'(last_rdy),      64'(1));
    check("bp_go_inst",  64'(bus.inst),      64'(32'h1234_5678));
    check("bp_go_valid", 64'(bus.out_valid), 64'(1));
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "bp_drain");
    check("bp_drain_valid", 64'(bus.out_valid), 64'(0));

    // Back-to-back: 12 beats, out_ready high.
    do_reset("b2b");
    b2b_words[0] = 32'h8C22_1234;
    b2b_words[1] = 32'h00A5_3020;
    b2b_words[2] = 32'hFFFF_FFFF;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, beat_of(b2b_words[c / 4], c % 4), 1'b1, 1'b0, "b2b");
      if (bus.out_valid) begin
        pulses++;
        got.push_back(bus.inst);
        pulse_cyc.push_back(c);
      end
    end
    check("b2b_pulses", 64'(pulses), 64'(3));
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      check($sformatf("b2b_inst%0d", i), 64'(got[i]),       64'(b2b_words[i]));
      check($sformatf("b2b_cyc%0d", i),  64'(pulse_cyc[i]), 64'(4 * i + 3));
    end

    // Flush mid-instruction.
    do_reset("fl");
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, "fl_pre");
    cycle(1'b1, 8'hBB, 1'b1, 1'b0, "fl_pre");
    cycle(1'b1, 8'hCC, 1'b1, 1'b1, "fl_flush");
    check("fl_busy", 64'(bus.busy), 64'(0));
    send_inst(I0, 1'b1, "fl_post");
    check("fl_inst",  64'(bus.inst),      64'(I0));
    check("fl_valid", 64'(bus.out_valid), 64'(1));

    // Reset mid-operation with an instruction pending.
    do_reset("rm");
    send_inst(32'hCAFE_F00D, 1'b0, "rm_a");
    for (int k = 0; k < 3; k++) cycle(1'b1, beat_of(32'h5555_AAAA, k), 1'b0, 1'b0, "rm_b");
    do_reset("rm_mid");
    send_inst(I0, 1'b1, "rm_post");
    check("rm_inst",   64'(bus.inst),   64'(I0));
    check("rm_addr_a", 64'(bus.addr_a), 64'(10));
    check("rm_mux_b",  64'(bus.mux_b),  64'(9));

    // Randomized traffic against the model.
    do_reset("rnd");
    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 19) == 0), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instruction_assembler.md
# instruction_assembler

Parametrised instruction register that assembles a `INST_W`-bit instruction from a stream of `DATA_W`-bit beats and presents it, with register-address fields decoded, to the datapath. It adds valid/ready flow control on both sides and a registered output stage, so the next instruction can be collected while the current one waits. It sits between the instruction-memory byte port and the register file / operand muxes.

## Interface
- `DATA_W`, 8: beat width in bits.
- `INST_W`, 32: instruction width. Must be a multiple of `DATA_W`, with `INST_W >= 32`.
- `BEATS`: derived as `INST_W/DATA_W`. Must be at least 2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: synchronous clear of a partial instruction and of the output stage.
- `in_data` input `DATA_W`: instruction beat.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block accepts a beat this cycle.
- `out_valid` output 1: `inst` and the decoded fields are valid.
- `out_ready` input 1: consumer takes the instruction this cycle.
- `inst` output `INST_W`: assembled instruction.
- `opcode` output 6: `inst[31:26]`.
- `addr_a` output 5: `inst[25:21]` (rs).
- `addr_b` output 5: `inst[20:16]` (rt).
- `mux_a` output 5: `inst[20:16]` (rt).
- `mux_b` output 5: `inst[15:11]` (rd).
- `imm` output 16: `inst[15:0]`.
- `busy` output 1: a partial instruction is held (`cnt != 0`).

## Operation
- **State.** The block holds:
  - beat counter `cnt`, width `$clog2(BEATS)`, range 0..BEATS-1;
  - assembly buffer `asm_q`, `INST_W` bits;
  - output stage: `inst`, the decoded field registers, and `out_valid`.
- **Accept.** A beat is accepted when `in_valid && in_ready`.
  - `in_ready = !flush && ((cnt != BEATS-1) || !out_valid || out_ready)`.
- **Beats other than the last** (`cnt < BEATS-1`): the beat is written into its lane of `asm_q` and `cnt` increments.
- **Last beat** (`cnt == BEATS-1`):
  - `inst` is loaded with `asm_q` merged with the final beat.
  - All decoded fields are registered from that same value in the same cycle.
  - `out_valid` is set to 1 and `cnt` wraps to 0.
- **Output drain.** `out_valid && out_ready` with no completing beat clears `out_valid`. Data registers hold their value.
- **Simultaneous drain and completion.** `out_valid` stays 1 and the new instruction replaces the old one. No bubble is inserted.
- **Backpressure.** If `out_valid && !out_ready`:
  - beats 0..BEATS-2 of the next instruction are still accepted;
  - the final beat stalls (`in_ready = 0`) until `out_ready` is asserted.
- **Flush.**
  - Clears `cnt` and `out_valid`.
  - Wins over a simultaneous accept or drain.
  - `asm_q` and the data registers keep stale contents.
- **Reset** (`rst_n` low, at any time, including mid-instruction):
  - `cnt = 0`, `asm_q = 0`, `out_valid = 0`;
  - `inst`, `opcode`, `addr_a`, `addr_b`, `mux_a`, `mux_b`, `imm` all 0;
  - `in_ready` = 1 once `rst_n` is high; `busy` = 0.
- **Unused bits.** For `INST_W > 32`, the fields are taken from bits [31:0] only.

## Timing
- **Latency.** Last beat accepted at edge N → `out_valid` and fields valid after edge N (visible in cycle N+1).
- **Throughput.** One instruction per `BEATS` cycles when `out_ready` is held high.
- **Outputs.** All outputs are registered, except `in_ready` and `busy`.
  - `in_ready` is combinational from `cnt`, `out_valid`, `out_ready` and `flush`.
  - `busy` is decoded from `cnt` alone.
- **Handshake rules.**
  - `out_valid`, once high, stays high and `inst` stays stable until a drain or flush.
  - `in_ready` may depend on `out_ready` in the same cycle.

## Configuration
- `INSTREG_BIG_ENDIAN_EN` undefined (default): beat k lands in `inst[DATA_W*k +: DATA_W]`, i.e. the first beat is least significant.
- `INSTREG_BIG_ENDIAN_EN` defined: beat k lands in `inst[INST_W-1-DATA_W*k -: DATA_W]`, i.e. the first beat is most significant.
- No other behaviour changes between the two builds.

## Test plan
All scenarios use `DATA_W=8`, `INST_W=32`.
- **Little-endian decode** (default build). Stimulus: beats 0x20, 0x48, 0x43, 0x01, `out_ready=1`. Required response:
  - `inst=0x01434820`, `opcode=0`;
  - `addr_a=10`, `addr_b=3`, `mux_a=3`, `mux_b=9`, `imm=0x4820`;
  - `out_valid` high for exactly 1 cycle, starting the cycle after the 4th beat.
- **Big-endian decode** (`INSTREG_BIG_ENDIAN_EN` build). Stimulus: beats 0x01, 0x43, 0x48, 0x20. Required response: the same `inst` and fields as the little-endian case.
- **Backpressure.** Stimulus: `out_ready=0`, stream 8 beats continuously. Required response:
  - first instruction held stable;
  - `in_ready` drops to 0 when the 8th beat is presented, with `busy=1`;
  - raise `out_ready` → first instruction drains, second loads the next cycle, `in_ready` returns to 1.
- **Back-to-back.** Stimulus: `out_ready=1`, 12 continuous beats. Required response: `out_valid` pulses once per 4 cycles, and 3 correct instructions are observed.
- **Flush mid-instruction.** Stimulus: 2 beats, then `flush` for 1 cycle, then beats 0x20, 0x48, 0x43, 0x01. Required response: `busy=0` after the flush, then `inst=0x01434820`.
- **Reset mid-operation.** Stimulus: `rst_n` asserted low asynchronously after 3 beats with a valid instruction pending. Required response:
  - all outputs 0 and `out_valid=0` immediately;
  - after release, a fresh 4-beat sequence decodes correctly.
